// File: rtl/mcycle_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package mcycle_pkg;

   localparam int unsigned MCYCLE_WIDTH = 32;
   localparam int unsigned MCYCLE_CNT_W = 6;

   typedef enum logic {
      MCYCLE_MUL = 1'b0,
      MCYCLE_DIV = 1'b1
   } mcycleOp_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_DONE    = 2'd2
   } mcycleState_e;

endpackage

// File: rtl/mcycle_if.sv
// Execute-stage issue / result hand-off bus of the multi-cycle unit.
interface mcycle_if #(
   parameter int unsigned WIDTH = mcycle_pkg::MCYCLE_WIDTH
) ();

   logic             Start;
   logic             MCycleOp;
   logic             Flush;
   logic [WIDTH-1:0] Operand1;
   logic [WIDTH-1:0] Operand2;
   logic [WIDTH-1:0] Result1;
   logic [WIDTH-1:0] Result2;
   logic             Busy;
   logic             Done;

   modport master (
      output Start, MCycleOp, Flush, Operand1, Operand2,
      input  Result1, Result2, Busy, Done
   );

   modport slave (
      input  Start, MCycleOp, Flush, Operand1, Operand2,
      output Result1, Result2, Busy, Done
   );

endinterface

// File: rtl/mcycle_iter_dp.sv
// Shift-add multiply / restoring divide datapath, one iteration per step.
// res1/res2 present the result words as they will be after the current step.
module mcycle_iter_dp
   import mcycle_pkg::*;
#(
   parameter int unsigned WIDTH = MCYCLE_WIDTH
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             load,
   input  logic             step,
   input  mcycleOp_e        op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic [WIDTH-1:0] res1,
   output logic [WIDTH-1:0] res2
);

   logic [2*WIDTH-1:0] acc;
   logic [WIDTH:0]     rem;
   logic [WIDTH-1:0]   opBQ;

   logic [WIDTH:0]     mulSum;
   logic [2*WIDTH-1:0] mulNext;
   logic [WIDTH:0]     divShift;
   logic [WIDTH:0]     divDiff;
   logic [WIDTH:0]     divNextRem;
   logic [WIDTH-1:0]   divNextQ;
   logic [2*WIDTH-1:0] accNext;
   logic [WIDTH:0]     remNext;

   // acc low half is the multiplier (MUL) or the dividend/quotient shift register (DIV)
   always_comb begin
      mulSum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opBQ} : (WIDTH+1)'(0));
      mulNext    = {mulSum, acc[WIDTH-1:1]};
      divShift   = {rem[WIDTH-1:0], acc[WIDTH-1]};
      divDiff    = divShift - {1'b0, opBQ};
      divNextRem = divDiff[WIDTH] ? divShift : divDiff;
      divNextQ   = {acc[WIDTH-2:0], ~divDiff[WIDTH]};
      accNext    = mulNext;
      remNext    = rem;
      res1       = mulNext[WIDTH-1:0];
      res2       = mulNext[2*WIDTH-1:WIDTH];
      if (op == MCYCLE_DIV) begin
         accNext = {acc[2*WIDTH-1:WIDTH], divNextQ};
         remNext = divNextRem;
         res1    = divNextQ;
         res2    = divNextRem[WIDTH-1:0];
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         acc  <= '0;
         rem  <= '0;
         opBQ <= '0;
      end else if (load) begin
         acc  <= {WIDTH'(0), opA};
         rem  <= '0;
         opBQ <= opB;
      end else if (step) begin
         acc  <= accNext;
         rem  <= remNext;
      end
   end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle execute sequencer: launches an op, steps the datapath WIDTH times,
// drives the E-stage stall (Busy) and registers the results for the M stage.
module mcycle_ctrl
   import mcycle_pkg::*;
#(
   parameter int unsigned WIDTH = MCYCLE_WIDTH,
   parameter int unsigned CNT_W = MCYCLE_CNT_W
) (
   input logic     CLK,
   input logic     Reset,
   mcycle_if.slave bus
);

   mcycleState_e     state;
   logic [CNT_W-1:0] iterCnt;
   mcycleOp_e        opQ;
   logic [WIDTH-1:0] result1Q;
   logic [WIDTH-1:0] result2Q;
   logic             doneQ;

   logic             launch;
   logic             lastIter;
   logic             dpLoad;
   logic             dpStep;
   logic [WIDTH-1:0] dpRes1;
   logic [WIDTH-1:0] dpRes2;

   assign launch   = (state == ST_IDLE) && bus.Start && !bus.Flush;
   assign lastIter = (iterCnt == CNT_W'(WIDTH - 1));
   assign dpLoad   = launch && !Reset;
   assign dpStep   = (state == ST_COMPUTE);

   // Busy must rise in the issue cycle itself so the instruction stalls in E at once
   assign bus.Busy    = !Reset && (launch || (state == ST_COMPUTE));
   assign bus.Done    = doneQ;
   assign bus.Result1 = result1Q;
   assign bus.Result2 = result2Q;

   mcycle_iter_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .CLK   (CLK),
      .Reset (Reset),
      .load  (dpLoad),
      .step  (dpStep),
      .op    (opQ),
      .opA   (bus.Operand1),
      .opB   (bus.Operand2),
      .res1  (dpRes1),
      .res2  (dpRes2)
   );

   // DONE ignores Start: the stalled instruction still asserts it while leaving E
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state    <= ST_IDLE;
         iterCnt  <= '0;
         opQ      <= MCYCLE_MUL;
         result1Q <= '0;
         result2Q <= '0;
         doneQ    <= 1'b0;
      end else begin
         doneQ <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (launch) begin
                  opQ     <= mcycleOp_e'(bus.MCycleOp);
                  iterCnt <= '0;
                  state   <= ST_COMPUTE;
               end
            end
            ST_COMPUTE: begin
               if (bus.Flush) begin
                  state <= ST_IDLE;
               end else if (lastIter) begin
                  result1Q <= dpRes1;
                  result2Q <= dpRes2;
                  doneQ    <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  iterCnt <= iterCnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed self-checking bench for mcycle_ctrl.
module tb_mcycle_ctrl;
   import mcycle_pkg::*;

   logic CLK;
   logic Reset;
   int   checks;
   int   failures;

   mcycle_if #(.WIDTH(32)) bus ();

   mcycle_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Issue one op with Start held through DONE, then drop Start; operands and op are
   // scrambled after launch. Returns Busy-cycle count, Done count and results seen at Done.
   task automatic launch_and_wait(input logic op, input logic [31:0] a, input logic [31:0] b,
                                  output int busyCnt, output int doneCnt,
                                  output logic [31:0] r1, output logic [31:0] r2);
      busyCnt = 0;
      doneCnt = 0;
      r1 = '0;
      r2 = '0;
      bus.Start    = 1'b1;
      bus.MCycleOp = op;
      bus.Operand1 = a;
      bus.Operand2 = b;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (bus.Busy) busyCnt++;
         if (bus.Done) begin
            doneCnt++;
            r1 = bus.Result1;
            r2 = bus.Result2;
         end
         @(posedge CLK);
         #1;
         if (c == 0) begin
            bus.Operand1 = $urandom;
            bus.Operand2 = $urandom;
            bus.MCycleOp = ~op;
         end
         if (doneCnt > 0) break;
      end
      bus.Start = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      bus.Start = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      checks += 4;
      if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
      if (bus.Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.Done); end
      if (bus.Result1 !== 32'h0) begin failures++; $display("FAIL reset_r1 got=%h exp=0", bus.Result1); end
      if (bus.Result2 !== 32'h0) begin failures++; $display("FAIL reset_r2 got=%h exp=0", bus.Result2); end
      bus.Start = 1'b0;
      Reset = 1'b0;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_mul_basic();
      int busyCnt, doneCnt;
      logic [31:0] r1, r2;
      launch_and_wait(1'b0, 32'd7, 32'd6, busyCnt, doneCnt, r1, r2);
      #1;
      checks += 7;
      if (busyCnt != 33) begin failures++; $display("FAIL mul7x6_busy got=%0d exp=33", busyCnt); end
      if (doneCnt != 1) begin failures++; $display("FAIL mul7x6_done got=%0d exp=1", doneCnt); end
      if (r1 !== 32'h0000002A) begin failures++; $display("FAIL mul7x6_r1 got=%h exp=0000002a", r1); end
      if (r2 !== 32'h0) begin failures++; $display("FAIL mul7x6_r2 got=%h exp=0", r2); end
      if (bus.Busy !== 1'b0) begin failures++; $display("FAIL mul7x6_relaunch_busy got=%b exp=0", bus.Busy); end
      if (bus.Done !== 1'b0) begin failures++; $display("FAIL mul7x6_done_pulse got=%b exp=0", bus.Done); end
      if (bus.Result1 !== 32'h0000002A) begin failures++; $display("FAIL mul7x6_hold got=%h exp=0000002a", bus.Result1); end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_mul_max();
      int busyCnt, doneCnt;
      logic [31:0] r1, r2;
      launch_and_wait(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, busyCnt, doneCnt, r1, r2);
      checks += 3;
      if (doneCnt != 1) begin failures++; $display("FAIL mulmax_done got=%0d exp=1", doneCnt); end
      if (r1 !== 32'h00000001) begin failures++; $display("FAIL mulmax_r1 got=%h exp=00000001", r1); end
      if (r2 !== 32'hFFFFFFFE) begin failures++; $display("FAIL mulmax_r2 got=%h exp=fffffffe", r2); end
   endtask

   task automatic test_div();
      int busyCnt, doneCnt;
      logic [31:0] r1, r2;
      launch_and_wait(1'b1, 32'd100, 32'd7, busyCnt, doneCnt, r1, r2);
      checks += 3;
      if (busyCnt != 33) begin failures++; $display("FAIL div100_busy got=%0d exp=33", busyCnt); end
      if (r1 !== 32'd14) begin failures++; $display("FAIL div100_q got=%0d exp=14", r1); end
      if (r2 !== 32'd2) begin failures++; $display("FAIL div100_r got=%0d exp=2", r2); end
   endtask

   task automatic test_div_zero();
      int busyCnt, doneCnt;
      logic [31:0] r1, r2;
      launch_and_wait(1'b1, 32'd5, 32'd0, busyCnt, doneCnt, r1, r2);
      checks += 4;
      if (busyCnt != 33) begin failures++; $display("FAIL divzero_busy got=%0d exp=33", busyCnt); end
      if (doneCnt != 1) begin failures++; $display("FAIL divzero_done got=%0d exp=1", doneCnt); end
      if (r1 !== 32'hFFFFFFFF) begin failures++; $display("FAIL divzero_q got=%h exp=ffffffff", r1); end
      if (r2 !== 32'd5) begin failures++; $display("FAIL divzero_r got=%0d exp=5", r2); end
   endtask

   task automatic test_flush();
      int busyCnt, doneCnt;
      logic [31:0] r1, r2;
      bus.Start = 1'b1;
      bus.MCycleOp = 1'b0;
      bus.Operand1 = 32'd3;
      bus.Operand2 = 32'd4;
      repeat (11) @(posedge CLK);
      #1;
      bus.Flush = 1'b1;
      bus.Start = 1'b0;
      @(posedge CLK);
      #1;
      bus.Flush = 1'b0;
      #1;
      checks += 4;
      if (bus.Busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", bus.Busy); end
      if (bus.Done !== 1'b0) begin failures++; $display("FAIL flush_done got=%b exp=0", bus.Done); end
      if (bus.Result1 !== 32'hFFFFFFFF) begin failures++; $display("FAIL flush_r1_hold got=%h exp=ffffffff", bus.Result1); end
      if (bus.Result2 !== 32'd5) begin failures++; $display("FAIL flush_r2_hold got=%h exp=5", bus.Result2); end
      launch_and_wait(1'b0, 32'd2, 32'd2, busyCnt, doneCnt, r1, r2);
      checks += 2;
      if (busyCnt != 33) begin failures++; $display("FAIL flush_relaunch_busy got=%0d exp=33", busyCnt); end
      if (r1 !== 32'd4) begin failures++; $display("FAIL flush_relaunch_r1 got=%0d exp=4", r1); end
      // Flush alongside Start in IDLE must suppress the launch
      bus.Start = 1'b1;
      bus.Flush = 1'b1;
      #1;
      checks += 1;
      if (bus.Busy !== 1'b0) begin failures++; $display("FAIL idleflush_busy got=%b exp=0", bus.Busy); end
      @(posedge CLK);
      #1;
      bus.Start = 1'b0;
      bus.Flush = 1'b0;
      #1;
      checks += 1;
      if (bus.Busy !== 1'b0) begin failures++; $display("FAIL idleflush_nolaunch got=%b exp=0", bus.Busy); end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset_mid();
      int busyCnt, doneCnt;
      logic [31:0] r1, r2;
      bus.Start = 1'b1;
      bus.MCycleOp = 1'b1;
      bus.Operand1 = 32'd1000;
      bus.Operand2 = 32'd3;
      repeat (6) @(posedge CLK);
      #1;
      Reset = 1'b1;
      #1;
      checks += 1;
      if (bus.Busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy_now got=%b exp=0", bus.Busy); end
      @(posedge CLK);
      #1;
      checks += 3;
      if (bus.Busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.Busy); end
      if (bus.Result1 !== 32'h0) begin failures++; $display("FAIL rstmid_r1 got=%h exp=0", bus.Result1); end
      if (bus.Result2 !== 32'h0) begin failures++; $display("FAIL rstmid_r2 got=%h exp=0", bus.Result2); end
      Reset = 1'b0;
      launch_and_wait(1'b1, 32'd1000, 32'd3, busyCnt, doneCnt, r1, r2);
      checks += 3;
      if (busyCnt != 33) begin failures++; $display("FAIL rstmid_relaunch_busy got=%0d exp=33", busyCnt); end
      if (r1 !== 32'd333) begin failures++; $display("FAIL rstmid_q got=%0d exp=333", r1); end
      if (r2 !== 32'd1) begin failures++; $display("FAIL rstmid_r got=%0d exp=1", r2); end
   endtask

   task automatic test_back_to_back();
      int busyCnt, doneCnt;
      logic [31:0] r1, r2;
      launch_and_wait(1'b0, 32'h00010000, 32'h00030000, busyCnt, doneCnt, r1, r2);
      checks += 2;
      if (r1 !== 32'h0) begin failures++; $display("FAIL b2b_mul_r1 got=%h exp=0", r1); end
      if (r2 !== 32'd3) begin failures++; $display("FAIL b2b_mul_r2 got=%h exp=3", r2); end
      launch_and_wait(1'b1, 32'hFFFFFFFF, 32'h10, busyCnt, doneCnt, r1, r2);
      checks += 4;
      if (busyCnt != 33) begin failures++; $display("FAIL b2b_div_busy got=%0d exp=33", busyCnt); end
      if (doneCnt != 1) begin failures++; $display("FAIL b2b_div_done got=%0d exp=1", doneCnt); end
      if (r1 !== 32'h0FFFFFFF) begin failures++; $display("FAIL b2b_div_q got=%h exp=0fffffff", r1); end
      if (r2 !== 32'hF) begin failures++; $display("FAIL b2b_div_r got=%h exp=f", r2); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      Reset = 1'b1;
      bus.Start = 1'b0;
      bus.MCycleOp = 1'b0;
      bus.Flush = 1'b0;
      bus.Operand1 = '0;
      bus.Operand2 = '0;
      test_reset();
      test_mul_basic();
      test_mul_max();
      test_div();
      test_div_zero();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mcycle_ctrl.md
Name: mcycle_ctrl

Overview:
Sequencer for the multi-cycle execute unit. It accepts a multiply or divide issued from the Execute stage and iterates a shift/add-subtract datapath for WIDTH cycles. It drives Busy, which the hazard unit consumes as M_BusyE to stall F/D/E and flush M. It registers both result words for hand-off to the Memory stage.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count equals WIDTH
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
Start  in  1  multi-cycle op present in E; may stay high throughout the stall
MCycleOp  in  1  0 = unsigned multiply, 1 = unsigned divide
Flush  in  1  synchronous abort of any in-flight op
Operand1  in  WIDTH  multiplicand / dividend
Operand2  in  WIDTH  multiplier / divisor
Result1  out  WIDTH  product low word / quotient
Result2  out  WIDTH  product high word / remainder
Busy  out  1  to hazard unit (M_BusyE)
Done  out  1  one-cycle pulse; results valid

Behaviour:
- One clock (CLK). Reset is synchronous and active-high. Reset is named Reset.
- Reset: state IDLE, counter 0, internal regs 0; Result1 = Result2 = 0, Done = 0. Busy = 0 whenever Reset is high.
- States: IDLE, COMPUTE, DONE (encoding in package).
- IDLE: if Start && !Flush at edge t, latch operands and op, clear counter and go to COMPUTE.
  - Busy is combinational: (state==IDLE && Start && !Flush) || state==COMPUTE.
  - Busy is therefore high in cycle t itself, so the issuing instruction stalls in E immediately.
- COMPUTE: one iteration per cycle, counter 0..WIDTH-1. On counter==WIDTH-1, register the results and go to DONE.
  - Busy stays high for exactly WIDTH+1 cycles, from t through t+WIDTH.
- Multiply: shift-add over a 2*WIDTH accumulator. Result2:Result1 = full unsigned product, no truncation.
- Divide: restoring, one quotient bit per iteration.
  - Result1 = quotient, Result2 = remainder.
  - Divide by zero yields no exception: quotient = all ones, remainder = dividend.
- DONE (cycle t+WIDTH+1): Busy = 0, Done = 1, results valid and held.
  - Start is ignored in this cycle, because the stalled instruction still asserts it while leaving E. This prevents a re-launch.
  - Next state is IDLE unconditionally.
- Result1/Result2 hold their last values until the next completion. They are not cleared on Start.
- Back-to-back: a new Start in the cycle after DONE is accepted normally. Minimum spacing between launches is WIDTH+2 cycles.
- Flush in COMPUTE: next state IDLE, Busy 0 from the next cycle. Results are not updated and Done is not pulsed.
- Flush in IDLE with Start: the op is not launched and Busy stays 0.
- Flush in DONE: no effect; Done still pulses.
- Operand changes after launch have no effect; only the latched operands are used.
- Reset mid-operation takes priority over everything. Next cycle: IDLE, Busy 0, results 0.
- Internal arithmetic widths:
  - Multiply accumulator: 2*WIDTH bits.
  - Divide partial remainder: WIDTH+1 bits, so the subtract borrow is visible.
  - Counter: CNT_W bits, never wraps during an op.

Decomposition:
- Package mcycle_pkg:
  - op encoding: MCYCLE_MUL = 1'b0, MCYCLE_DIV = 1'b1
  - state encoding for IDLE, COMPUTE, DONE
  - default WIDTH constant
- One sub-module, mcycle_iter_dp: pure datapath holding the accumulator/remainder and shift register.
  - Controls: load, step, op.
  - Outputs: the two result words.
- mcycle_ctrl owns the FSM, counter, Busy/Done and the result registers.

Test Plan:
- MCycleOp=0, Operand1=7, Operand2=6, Start held high through DONE:
  - Busy high 33 cycles.
  - Done pulses once, with Result1=0x0000002A and Result2=0.
  - No second launch.
- Multiply 0xFFFFFFFF × 0xFFFFFFFF -> Result2=0xFFFFFFFE, Result1=0x00000001.
- MCycleOp=1, 100 ÷ 7 -> Result1=14, Result2=2.
- Divide 5 ÷ 0 -> Result1=0xFFFFFFFF, Result2=5, with normal 33-cycle Busy.
- Launch multiply 3×4, assert Flush at iteration 10:
  - Busy 0 next cycle, no Done, results keep their prior values.
  - A new 2×2 launched the following cycle completes with Result1=4.
- Launch divide 1000÷3, assert Reset at iteration 5:
  - Next cycle Busy=0 and Result1=Result2=0.
  - With Start still high after Reset deasserts, a fresh op launches and returns 333 remainder 1.
